// File: rtl/deflate_sched_pkg.sv
// Shared scheduling definitions for the deflate engine dispatcher and the
// output collector.
package deflate_sched_pkg;

  localparam int NUM_ENGINES_DEF = 4;
  localparam int SEQ_W_DEF       = 8;
  localparam int ENG_IDX_W_DEF   = $clog2(NUM_ENGINES_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[IDX_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/deflate_engine_dispatcher.sv
// Distributes jobs from one 256-bit stream across parallel deflate engines,
// round-robin over idle enabled engines, and logs each dispatch in order.
module deflate_engine_dispatcher
  import deflate_sched_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int ENG_IDX_W   = $clog2(NUM_ENGINES),
  parameter int SEQ_W       = SEQ_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [255:0]           in_data,
  input  logic                   in_last,
  input  logic [NUM_ENGINES-1:0] eng_enable,
  input  logic [NUM_ENGINES-1:0] eng_out_last,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [NUM_ENGINES-1:0] eng_inValid,
  output logic [NUM_ENGINES-1:0] eng_last,
  output logic [255:0]           eng_data,
  output logic [NUM_ENGINES-1:0] eng_busy,
  output logic                   dispatch_valid,
  output logic [ENG_IDX_W-1:0]   dispatch_engine,
  output logic [SEQ_W-1:0]       dispatch_seq
);

  state_t                 state_q, state_d;
  logic [ENG_IDX_W-1:0]   sel_q, sel_d, ptr_q, ptr_d;
  logic                   first_q, first_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [NUM_ENGINES-1:0] start_q, start_d, invalid_q, invalid_d, last_q, last_d;
  logic [255:0]           data_q, data_d;
  logic                   dv_q, dv_d;
  logic [ENG_IDX_W-1:0]   de_q, de_d;
  logic [SEQ_W-1:0]       ds_q, ds_d;

  logic                   grant_valid;
  logic [ENG_IDX_W-1:0]   grant_idx;
  logic [NUM_ENGINES-1:0] sel_oh;

  rr_arbiter #(
    .N     (NUM_ENGINES),
    .IDX_W (ENG_IDX_W)
  ) u_rr_arbiter (
    .req         (eng_enable & ~busy_q),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_oh = {{(NUM_ENGINES-1){1'b0}}, 1'b1} << sel_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    seq_d     = seq_q;
    busy_d    = busy_q & ~eng_out_last;
    start_d   = '0;
    invalid_d = '0;
    last_d    = '0;
    data_d    = data_q;
    dv_d      = 1'b0;
    de_d      = de_q;
    ds_d      = ds_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && grant_valid) begin
          sel_d   = grant_idx;
          first_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (in_valid) begin
          invalid_d = sel_oh;
          data_d    = in_data;
          start_d   = first_q ? sel_oh : '0;
          last_d    = in_last ? sel_oh : '0;
          if (first_q) begin
            dv_d    = 1'b1;
            de_d    = sel_q;
            ds_d    = seq_q;
            seq_d   = seq_q + 1'b1;
            first_d = 1'b0;
          end
          if (in_last) begin
            // NOTE: the set is applied after the out_last clear, so a same-cycle set wins.
            busy_d  = busy_d | sel_oh;
            ptr_d   = (sel_q == ENG_IDX_W'(NUM_ENGINES - 1)) ? '0 : sel_q + 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments; reset also clears eng_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      seq_q     <= '0;
      busy_q    <= '0;
      start_q   <= '0;
      invalid_q <= '0;
      last_q    <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      de_q      <= '0;
      ds_q      <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      seq_q     <= seq_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      invalid_q <= invalid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      de_q      <= de_d;
      ds_q      <= ds_d;
    end
  end

  assign in_ready        = (state_q == STREAM);
  assign eng_start       = start_q;
  assign eng_inValid     = invalid_q;
  assign eng_last        = last_q;
  assign eng_data        = data_q;
  assign eng_busy        = busy_q;
  assign dispatch_valid  = dv_q;
  assign dispatch_engine = de_q;
  assign dispatch_seq    = ds_q;

endmodule

// File: tb/tb_deflate_engine_dispatcher.sv
// Randomized bench for deflate_engine_dispatcher: a job-level reference model
// predicts every output each cycle, plus directed scenario checks.
module tb_deflate_engine_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_last;
  logic [3:0]   eng_enable;
  logic [3:0]   eng_out_last;
  logic [3:0]   eng_start;
  logic [3:0]   eng_inValid;
  logic [3:0]   eng_last;
  logic [255:0] eng_data;
  logic [3:0]   eng_busy;
  logic         dispatch_valid;
  logic [1:0]   dispatch_engine;
  logic [7:0]   dispatch_seq;

  int vectors    = 0;
  int miscompares = 0;

  deflate_engine_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .eng_enable      (eng_enable),
    .eng_out_last    (eng_out_last),
    .eng_start       (eng_start),
    .eng_inValid     (eng_inValid),
    .eng_last        (eng_last),
    .eng_data        (eng_data),
    .eng_busy        (eng_busy),
    .dispatch_valid  (dispatch_valid),
    .dispatch_engine (dispatch_engine),
    .dispatch_seq    (dispatch_seq)
  );

  always #5 clk = ~clk;

  // Reference model: tracks which engine owns the job being streamed, which
  // engines hold unfinished jobs, the next-choice pointer and the job counter.
  logic         m_streaming = 1'b0;
  logic         m_first     = 1'b0;
  logic         m_accepted  = 1'b0;
  int           m_job       = 0;
  int           m_ptr       = 0;
  int           m_seq       = 0;
  int           m_pick;
  logic [3:0]   m_busy = '0, m_nb = '0;
  logic [3:0]   m_start = '0, m_inv = '0, m_last = '0;
  logic         m_dv = 1'b0;
  logic [1:0]   m_de = '0;
  logic [7:0]   m_ds = '0;
  logic [255:0] m_data = '0;

  always @(posedge clk) begin
    m_accepted = 1'b0;
    if (rst) begin
      m_streaming = 1'b0; m_first = 1'b0; m_job = 0; m_ptr = 0; m_seq = 0;
      m_busy = '0; m_start = '0; m_inv = '0; m_last = '0;
      m_dv = 1'b0; m_de = '0; m_ds = '0; m_data = '0;
    end else begin
      m_nb = m_busy & ~eng_out_last;
      m_start = '0; m_inv = '0; m_last = '0; m_dv = 1'b0;
      if (!m_streaming) begin
        m_pick = -1;
        for (int k = 0; k < 4; k++)
          if (m_pick < 0 && eng_enable[(m_ptr + k) % 4] && !m_busy[(m_ptr + k) % 4])
            m_pick = (m_ptr + k) % 4;
        if (in_valid && m_pick >= 0) begin
          m_job = m_pick; m_first = 1'b1; m_streaming = 1'b1;
        end
      end else if (in_valid) begin
        m_accepted     = 1'b1;
        m_inv[m_job]   = 1'b1;
        m_data         = in_data;
        m_start[m_job] = m_first;
        m_last[m_job]  = in_last;
        if (m_first) begin
          m_dv = 1'b1; m_de = 2'(m_job); m_ds = 8'(m_seq);
          m_seq = (m_seq + 1) % 256; m_first = 1'b0;
        end
        if (in_last) begin
          m_nb[m_job] = 1'b1; m_ptr = (m_job + 1) % 4; m_streaming = 1'b0;
        end
      end
      m_busy = m_nb;
    end
  end

  wire [283:0] obs = {in_ready, eng_start, eng_inValid, eng_last, eng_busy,
                      dispatch_valid, dispatch_engine, dispatch_seq, eng_data};
  wire [283:0] exp_vec = {m_streaming, m_start, m_inv, m_last, m_busy,
                          m_dv, m_de, m_ds, m_data};

  logic [9:0] disp_q[$];
  logic [3:0] seen_inv;

  // Advance one clock and compare the full output vector with the model.
  task automatic tick();
    @(posedge clk); #1;
    vectors++;
    if (obs !== exp_vec) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, obs, exp_vec);
    end
    seen_inv = seen_inv | eng_inValid;
    if (dispatch_valid) disp_q.push_back({dispatch_engine, dispatch_seq});
  endtask

  function automatic logic [255:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; eng_out_last = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic release_all();
    eng_out_last = 4'hF; tick();
    eng_out_last = '0;   tick();
  endtask

  // Offer one job of len words; optional random valid gaps, an out_last pulse
  // on cycle pulse_cyc, and a reset after abort_after accepted words.
  task automatic send_job(input int len, input bit gaps, input int pulse_cyc,
                          input logic [3:0] pulse_mask, input int abort_after,
                          output int first_acc);
    int w = 0;
    int cyc = 0;
    logic [255:0] word = rand_word();
    first_acc = 0;
    while (w < len && cyc < 300) begin
      cyc++;
      in_valid     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data      = word;
      in_last      = (w == len - 1);
      eng_out_last = (cyc == pulse_cyc) ? pulse_mask : 4'h0;
      tick();
      if (m_accepted) begin
        if (first_acc == 0) first_acc = cyc;
        w++;
        word = rand_word();
        if (w == abort_after) begin
          rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; eng_out_last = '0;
          tick();
          rst = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0; eng_out_last = '0;
    if (w < len) begin
      vectors++; miscompares++;
      $display("FAIL job_timeout accepted=%0d required=%0d", w, len);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_state actual=%h required=0", obs);
    end
  endtask

  task automatic test_three_jobs();
    int fa;
    do_reset();
    disp_q.delete();
    for (int j = 0; j < 3; j++) begin
      send_job(4, 1'b0, 0, 4'h0, 0, fa);
      vectors++;
      if (fa !== 2) begin
        miscompares++;
        $display("FAIL bubble_cycles job=%0d accept_cycle=%0d required=2", j, fa);
      end
    end
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (disp_q.size() <= j || disp_q[j] !== {2'(j), 8'(j)}) begin
        miscompares++;
        $display("FAIL three_jobs_dispatch job=%0d actual=%h required=%h",
                 j, (disp_q.size() > j) ? disp_q[j] : 10'h3ff, {2'(j), 8'(j)});
      end
    end
  endtask

  task automatic test_single_word();
    int fa;
    do_reset();
    send_job(1, 1'b0, 0, 4'h0, 0, fa);
    vectors++;
    if ({eng_start, eng_last, eng_busy} !== {4'b0001, 4'b0001, 4'b0001}) begin
      miscompares++;
      $display("FAIL single_word start/last/busy actual=%b_%b_%b required=0001_0001_0001",
               eng_start, eng_last, eng_busy);
    end
  endtask

  task automatic test_fill();
    int fa;
    do_reset();
    disp_q.delete();
    for (int j = 0; j < 4; j++) send_job(1, 1'b0, 0, 4'h0, 0, fa);
    send_job(2, 1'b0, 6, 4'b0100, 0, fa);
    vectors++;
    if (fa !== 8) begin
      miscompares++;
      $display("FAIL fill_wait accept_cycle=%0d required=8", fa);
    end
    vectors++;
    if (disp_q.size() != 5 || disp_q[4] !== {2'd2, 8'd4}) begin
      miscompares++;
      $display("FAIL fill_engine count=%0d last=%h required=%h",
               disp_q.size(), (disp_q.size() > 0) ? disp_q[$] : 10'h3ff, {2'd2, 8'd4});
    end
  endtask

  task automatic test_mask();
    int fa;
    do_reset();
    disp_q.delete();
    seen_inv = '0;
    eng_enable = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      release_all();
      send_job($urandom_range(1, 3), 1'b1, 0, 4'h0, 0, fa);
    end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (disp_q.size() <= j || disp_q[j][9:8] !== ((j % 2 == 0) ? 2'd1 : 2'd3)) begin
        miscompares++;
        $display("FAIL mask_alternate job=%0d actual=%h", j,
                 (disp_q.size() > j) ? disp_q[j] : 10'h3ff);
      end
    end
    vectors++;
    if ((seen_inv & 4'b0101) !== 4'b0000) begin
      miscompares++;
      $display("FAIL mask_disabled_strobe seen=%b required=x0x0", seen_inv);
    end
    eng_enable = 4'hF;
  endtask

  task automatic test_back_to_back_wrap();
    int fa;
    int bad = 0;
    do_reset();
    disp_q.delete();
    for (int j = 0; j < 260; j++) begin
      release_all();
      send_job($urandom_range(1, 2), 1'b1, 0, 4'h0, 0, fa);
    end
    vectors++;
    if (disp_q.size() != 260) begin
      miscompares++;
      $display("FAIL wrap_count actual=%0d required=260", disp_q.size());
    end else begin
      for (int j = 0; j < 260; j++)
        if (disp_q[j] !== {2'(j % 4), 8'(j % 256)}) bad++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL wrap_order bad_records=%0d required=0", bad);
      end
      vectors++;
      if (disp_q[256][7:0] !== 8'd0) begin
        miscompares++;
        $display("FAIL wrap_seq job257 actual=%0d required=0", disp_q[256][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int fa;
    do_reset();
    send_job(1, 1'b0, 0, 4'h0, 0, fa);
    send_job(4, 1'b0, 0, 4'h0, 2, fa);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_job actual=%h required=0", obs);
    end
    disp_q.delete();
    send_job(2, 1'b0, 0, 4'h0, 0, fa);
    vectors++;
    if (disp_q.size() != 1 || disp_q[0] !== 10'h000) begin
      miscompares++;
      $display("FAIL after_reset_dispatch actual=%h required=000",
               (disp_q.size() > 0) ? disp_q[0] : 10'h3ff);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    eng_enable = 4'hF; eng_out_last = '0; seen_inv = '0;
    test_reset();
    test_three_jobs();
    test_single_word();
    test_fill();
    test_mask();
    test_back_to_back_wrap();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
